// File: rtl/decode_ctrl_alu_pkg.sv
// Shared RV32I decode definitions: opcode values, ALU operation codes and
// instruction formats, plus the func3 -> ALU operation mapping helpers.
package decode_ctrl_alu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [5:0] {
        ALU_ADD   = 6'd0,
        ALU_SUB   = 6'd1,
        ALU_SLL   = 6'd2,
        ALU_SLT   = 6'd3,
        ALU_SLTU  = 6'd4,
        ALU_XOR   = 6'd5,
        ALU_SRL   = 6'd6,
        ALU_SRA   = 6'd7,
        ALU_OR    = 6'd8,
        ALU_AND   = 6'd9,
        ALU_BEQ   = 6'd16,
        ALU_BNE   = 6'd17,
        ALU_BLT   = 6'd18,
        ALU_BGE   = 6'd19,
        ALU_BLTU  = 6'd20,
        ALU_BGEU  = 6'd21,
        ALU_LUI   = 6'd32,
        ALU_AUIPC = 6'd33,
        ALU_LINK  = 6'd34
    } alu_op_e;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_SB,
        FMT_U,
        FMT_UJ
    } fmt_e;

    // alt carries instr[30]; callers decide when it is allowed to mean SUB/SRA.
    function automatic alu_op_e arith_op(input logic [2:0] func3, input logic alt);
        alu_op_e op;
        case (func3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic alu_op_e branch_op(input logic [2:0] func3);
        alu_op_e op;
        case (func3)
            3'b000:  op = ALU_BEQ;
            3'b001:  op = ALU_BNE;
            3'b100:  op = ALU_BLT;
            3'b101:  op = ALU_BGE;
            3'b110:  op = ALU_BLTU;
            3'b111:  op = ALU_BGEU;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_ctrl_alu_exec.sv
// Pure combinational RV32I ALU: arithmetic/logic result plus branch condition.
module decode_ctrl_alu_exec
    import decode_ctrl_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e           i_alu_op,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    input  logic [XLEN-1:0]   i_pc,
    output logic [XLEN-1:0]   o_result,
    output logic              o_branch
);

    logic signed [XLEN-1:0] w_a_s;
    logic signed [XLEN-1:0] w_b_s;
    logic        [4:0]      w_shamt;
    logic                   w_lt_s;
    logic                   w_lt_u;
    logic                   w_eq;

    assign w_a_s   = i_a;
    assign w_b_s   = i_b;
    assign w_shamt = i_b[4:0];
    assign w_lt_s  = w_a_s < w_b_s;
    assign w_lt_u  = i_a < i_b;
    assign w_eq    = i_a == i_b;

    // Branch ops only raise the flag; their result stays zero.
    always_comb begin
        o_result = '0;
        o_branch = 1'b0;
        case (i_alu_op)
            ALU_ADD:   o_result = i_a + i_b;
            ALU_SUB:   o_result = i_a - i_b;
            ALU_SLL:   o_result = i_a << w_shamt;
            ALU_SLT:   o_result = {{(XLEN-1){1'b0}}, w_lt_s};
            ALU_SLTU:  o_result = {{(XLEN-1){1'b0}}, w_lt_u};
            ALU_XOR:   o_result = i_a ^ i_b;
            ALU_SRL:   o_result = i_a >> w_shamt;
            ALU_SRA:   o_result = w_a_s >>> w_shamt;
            ALU_OR:    o_result = i_a | i_b;
            ALU_AND:   o_result = i_a & i_b;
            ALU_BEQ:   o_branch = w_eq;
            ALU_BNE:   o_branch = !w_eq;
            ALU_BLT:   o_branch = w_lt_s;
            ALU_BGE:   o_branch = !w_lt_s;
            ALU_BLTU:  o_branch = w_lt_u;
            ALU_BGEU:  o_branch = !w_lt_u;
            ALU_LUI:   o_result = i_b;
            ALU_AUIPC: o_result = i_pc + i_b;
            ALU_LINK:  o_result = i_pc + XLEN'(4);
            default:   o_result = '0;
        endcase
    end

endmodule

// File: rtl/decode_ctrl_alu.sv
// RV32I decode/control slice with a registered ALU result.
// Optional DEC_ILLEGAL_EN adds illegal_o and suppresses write/branch/jump on bad encodings.
module decode_ctrl_alu
    import decode_ctrl_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              regrst_ni,
    input  logic [31:0]       instr_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    output logic [4:0]        RS1_o,
    output logic [4:0]        RS2_o,
    output logic [4:0]        RD_o,
    output logic [6:0]        opcode_o,
    output logic [2:0]        func3_o,
    output logic [6:0]        func7_o,
    output logic [XLEN-1:0]   immed_o,
    output logic              I_EN_o,
    output logic              R_EN_o,
    output logic              S_EN_o,
    output logic              SB_EN_o,
    output logic              U_EN_o,
    output logic              UJ_EN_o,
    output logic              RWR_EN_o,
    output logic              BE_o,
    output logic              JALRE_o,
    output logic              UJE_o,
    output logic              IWR_EN_o,
    output logic              IR_EN_o,
    output logic [5:0]        ALUop_o,
    output logic [XLEN-1:0]   result_o
`ifdef DEC_ILLEGAL_EN
    ,
    output logic              illegal_o
`endif
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_func3;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_sb;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_uj;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_result;
    fmt_e            w_fmt;
    alu_op_e         w_aluop;
    logic            w_wr;
    logic            w_jalr;
    logic            w_jal;
    logic            w_use_rs2;
    logic            w_branch;
    logic            w_kill;
    logic            w_ctrl_ok;
    logic [XLEN-1:0] r_result;

    assign w_opcode = instr_i[6:0];
    assign w_func3  = instr_i[14:12];

    assign RS1_o    = instr_i[19:15];
    assign RS2_o    = instr_i[24:20];
    assign RD_o     = instr_i[11:7];
    assign opcode_o = w_opcode;
    assign func3_o  = w_func3;
    assign func7_o  = instr_i[31:25];

    assign w_imm_i  = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign w_imm_s  = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign w_imm_sb = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7],
                       instr_i[30:25], instr_i[11:8], 1'b0};
    assign w_imm_u  = {instr_i[31:12], 12'b0};
    assign w_imm_uj = {{(XLEN-21){instr_i[31]}}, instr_i[31], instr_i[19:12],
                       instr_i[20], instr_i[30:21], 1'b0};

    // OP-IMM only lets instr[30] select SRA; ADDI with that bit set stays ADD.
    always_comb begin
        w_fmt     = FMT_NONE;
        w_aluop   = ALU_ADD;
        w_imm     = '0;
        w_wr      = 1'b0;
        w_jalr    = 1'b0;
        w_jal     = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_fmt     = FMT_R;
                w_wr      = 1'b1;
                w_use_rs2 = 1'b1;
                w_aluop   = arith_op(w_func3, instr_i[30]);
            end
            OPC_OP_IMM: begin
                w_fmt   = FMT_I;
                w_wr    = 1'b1;
                w_imm   = w_imm_i;
                w_aluop = arith_op(w_func3, (w_func3 == 3'b101) && instr_i[30]);
            end
            OPC_LOAD: begin
                w_fmt = FMT_I;
                w_wr  = 1'b1;
                w_imm = w_imm_i;
            end
            OPC_JALR: begin
                w_fmt   = FMT_I;
                w_wr    = 1'b1;
                w_jalr  = 1'b1;
                w_imm   = w_imm_i;
                w_aluop = ALU_LINK;
            end
            OPC_STORE: begin
                w_fmt = FMT_S;
                w_imm = w_imm_s;
            end
            OPC_BRANCH: begin
                w_fmt     = FMT_SB;
                w_use_rs2 = 1'b1;
                w_imm     = w_imm_sb;
                w_aluop   = branch_op(w_func3);
            end
            OPC_LUI: begin
                w_fmt   = FMT_U;
                w_wr    = 1'b1;
                w_imm   = w_imm_u;
                w_aluop = ALU_LUI;
            end
            OPC_AUIPC: begin
                w_fmt   = FMT_U;
                w_wr    = 1'b1;
                w_imm   = w_imm_u;
                w_aluop = ALU_AUIPC;
            end
            OPC_JAL: begin
                w_fmt   = FMT_UJ;
                w_wr    = 1'b1;
                w_jal   = 1'b1;
                w_imm   = w_imm_uj;
                w_aluop = ALU_LINK;
            end
            default: ;
        endcase
    end

`ifdef DEC_ILLEGAL_EN
    logic w_illegal;

    always_comb begin
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_illegal = !((func7_o == 7'b0000000) ||
                              ((func7_o == 7'b0100000) &&
                               ((w_func3 == 3'b000) || (w_func3 == 3'b101))));
            end
            OPC_BRANCH: w_illegal = (w_func3[2:1] == 2'b01);
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_STORE,
            OPC_LUI, OPC_AUIPC, OPC_JAL: w_illegal = 1'b0;
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_kill    = w_illegal;
    assign illegal_o = regrst_ni & w_illegal;
`else
    assign w_kill = 1'b0;
`endif

    assign w_op_b = w_use_rs2 ? rs2_data_i : w_imm;

    decode_ctrl_alu_exec #(
        .XLEN (XLEN)
    ) u_exec (
        .i_alu_op (w_aluop),
        .i_a      (rs1_data_i),
        .i_b      (w_op_b),
        .i_pc     (pc_i),
        .o_result (w_result),
        .o_branch (w_branch)
    );

    // Every control output is held low while reset is asserted.
    assign w_ctrl_ok = regrst_ni & ~w_kill;

    assign immed_o  = w_imm;
    assign I_EN_o   = regrst_ni & (w_fmt == FMT_I);
    assign R_EN_o   = regrst_ni & (w_fmt == FMT_R);
    assign S_EN_o   = regrst_ni & (w_fmt == FMT_S);
    assign SB_EN_o  = regrst_ni & (w_fmt == FMT_SB);
    assign U_EN_o   = regrst_ni & (w_fmt == FMT_U);
    assign UJ_EN_o  = regrst_ni & (w_fmt == FMT_UJ);
    assign RWR_EN_o = w_ctrl_ok & w_wr & (RD_o != 5'd0);
    assign BE_o     = w_ctrl_ok & w_branch;
    assign JALRE_o  = w_ctrl_ok & w_jalr;
    assign UJE_o    = w_ctrl_ok & w_jal;
    assign IWR_EN_o = 1'b0;
    assign IR_EN_o  = regrst_ni;
    assign ALUop_o  = regrst_ni ? w_aluop : ALU_ADD;

    always_ff @(posedge clk_i or negedge regrst_ni) begin
        if (!regrst_ni) begin
            r_result <= '0;
        end else begin
            r_result <= w_result;
        end
    end

    assign result_o = r_result;

endmodule

// File: tb/tb_decode_ctrl_alu.sv
// Self-checking bench for decode_ctrl_alu: directed cases plus a random
// back-to-back instruction stream checked against an instruction-level model.
module tb_decode_ctrl_alu;

    logic        clk_i = 1'b0;
    logic        regrst_ni;
    logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i;
    logic [4:0]  RS1_o, RS2_o, RD_o;
    logic [6:0]  opcode_o, func7_o;
    logic [2:0]  func3_o;
    logic [31:0] immed_o, result_o;
    logic        I_EN_o, R_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o;
    logic        RWR_EN_o, BE_o, JALRE_o, UJE_o, IWR_EN_o, IR_EN_o;
    logic [5:0]  ALUop_o;
`ifdef DEC_ILLEGAL_EN
    logic        illegal_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    decode_ctrl_alu dut (
        .clk_i(clk_i), .regrst_ni(regrst_ni), .instr_i(instr_i), .pc_i(pc_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .RS1_o(RS1_o), .RS2_o(RS2_o), .RD_o(RD_o), .opcode_o(opcode_o),
        .func3_o(func3_o), .func7_o(func7_o), .immed_o(immed_o),
        .I_EN_o(I_EN_o), .R_EN_o(R_EN_o), .S_EN_o(S_EN_o), .SB_EN_o(SB_EN_o),
        .U_EN_o(U_EN_o), .UJ_EN_o(UJ_EN_o), .RWR_EN_o(RWR_EN_o), .BE_o(BE_o),
        .JALRE_o(JALRE_o), .UJE_o(UJE_o), .IWR_EN_o(IWR_EN_o), .IR_EN_o(IR_EN_o),
        .ALUop_o(ALUop_o), .result_o(result_o)
`ifdef DEC_ILLEGAL_EN
        , .illegal_o(illegal_o)
`endif
    );

    typedef struct packed {
        logic [31:0] imm;
        logic [5:0]  op;
        logic [5:0]  en;   // {I,R,S,SB,U,UJ}
        logic        rwr;
        logic        be;
        logic        jalr;
        logic        jal;
        logic        ill;
        logic [31:0] res;
    } exp_t;

    function automatic void arith(input logic [2:0] f3, input logic alt,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [5:0] code, output logic [31:0] res);
        int unsigned sh;
        sh = b % 32;
        case (f3)
            3'd0: begin code = alt ? 6'd1 : 6'd0; res = alt ? a - b : a + b; end
            3'd1: begin code = 6'd2; res = a << sh; end
            3'd2: begin code = 6'd3; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
            3'd3: begin code = 6'd4; res = (a < b) ? 32'd1 : 32'd0; end
            3'd4: begin code = 6'd5; res = a ^ b; end
            3'd5: begin code = alt ? 6'd7 : 6'd6; res = alt ? 32'($signed(a) >>> sh) : a >> sh; end
            3'd6: begin code = 6'd8; res = a | b; end
            default: begin code = 6'd9; res = a & b; end
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] r2);
        exp_t e;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] ii, is, ib, iu, ij;
        f3 = ins[14:12];
        f7 = ins[31:25];
        ii = 32'($signed(ins[31:20]));
        is = 32'($signed({ins[31:25], ins[11:7]}));
        ib = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        iu = {ins[31:12], 12'h000};
        ij = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        e = '0;
        case (ins[6:0])
            7'h33: begin
                e.en = 6'b010000; e.rwr = 1'b1;
                arith(f3, f7[5], a, r2, e.op, e.res);
                e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            7'h13: begin
                e.en = 6'b100000; e.rwr = 1'b1; e.imm = ii;
                arith(f3, (f3 == 3'd5) && f7[5], a, ii, e.op, e.res);
            end
            7'h03: begin e.en = 6'b100000; e.rwr = 1'b1; e.imm = ii; e.res = a + ii; end
            7'h67: begin
                e.en = 6'b100000; e.rwr = 1'b1; e.jalr = 1'b1; e.imm = ii;
                e.op = 6'd34; e.res = pc + 32'd4;
            end
            7'h23: begin e.en = 6'b001000; e.imm = is; e.res = a + is; end
            7'h63: begin
                e.en = 6'b000100; e.imm = ib;
                case (f3)
                    3'd0: begin e.op = 6'd16; e.be = (a == r2); end
                    3'd1: begin e.op = 6'd17; e.be = (a != r2); end
                    3'd4: begin e.op = 6'd18; e.be = ($signed(a) < $signed(r2)); end
                    3'd5: begin e.op = 6'd19; e.be = ($signed(a) >= $signed(r2)); end
                    3'd6: begin e.op = 6'd20; e.be = (a < r2); end
                    3'd7: begin e.op = 6'd21; e.be = (a >= r2); end
                    default: begin e.op = 6'd0; e.res = a + r2; e.ill = 1'b1; end
                endcase
            end
            7'h37: begin e.en = 6'b000010; e.rwr = 1'b1; e.imm = iu; e.op = 6'd32; e.res = iu; end
            7'h17: begin e.en = 6'b000010; e.rwr = 1'b1; e.imm = iu; e.op = 6'd33; e.res = pc + iu; end
            7'h6F: begin
                e.en = 6'b000001; e.rwr = 1'b1; e.jal = 1'b1; e.imm = ij;
                e.op = 6'd34; e.res = pc + 32'd4;
            end
            default: begin e.res = a; e.ill = 1'b1; end
        endcase
        if (ins[11:7] == 5'd0) e.rwr = 1'b0;
`ifdef DEC_ILLEGAL_EN
        if (e.ill) begin e.rwr = 1'b0; e.be = 1'b0; e.jalr = 1'b0; e.jal = 1'b0; end
`endif
        return e;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
        instr_i = ins; pc_i = pc; rs1_data_i = a; rs2_data_i = b;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        regrst_ni = 1'b0;
        drive(32'hFFB00093, 32'h0, 32'h0, 32'h0);
        #2;
        total++; if (result_o !== 32'h0) begin bad++; $display("FAIL rst_result got=%h want=0", result_o); end
        total++; if (IR_EN_o !== 1'b0) begin bad++; $display("FAIL rst_ir_en got=%b want=0", IR_EN_o); end
        total++; if (RWR_EN_o !== 1'b0) begin bad++; $display("FAIL rst_rwr got=%b want=0", RWR_EN_o); end
        step(); step();
        total++; if (result_o !== 32'h0) begin bad++; $display("FAIL rst_hold_result got=%h want=0", result_o); end
        regrst_ni = 1'b1;
        #1;
        total++; if (IR_EN_o !== 1'b1) begin bad++; $display("FAIL rel_ir_en got=%b want=1", IR_EN_o); end
        total++; if (IWR_EN_o !== 1'b0) begin bad++; $display("FAIL iwr_en got=%b want=0", IWR_EN_o); end
        drive(32'h23400093, 32'h0, 32'h1000, 32'h0);
        step();
        total++; if (result_o !== 32'h1234) begin bad++; $display("FAIL pre_rst_result got=%h want=1234", result_o); end
        #2 regrst_ni = 1'b0;
        #1;
        total++; if (result_o !== 32'h0) begin bad++; $display("FAIL midrun_rst_result got=%h want=0", result_o); end
        total++; if (IR_EN_o !== 1'b0 || RWR_EN_o !== 1'b0 || I_EN_o !== 1'b0)
            begin bad++; $display("FAIL midrun_rst_ctrl got=%b%b%b want=000", IR_EN_o, RWR_EN_o, I_EN_o); end
        @(negedge clk_i);
        regrst_ni = 1'b1;
        #1;
        total++; if (IR_EN_o !== 1'b1) begin bad++; $display("FAIL rerel_ir_en got=%b want=1", IR_EN_o); end
    endtask

    task automatic test_alu_ops();
        drive(32'hFFB00093, 32'h0, 32'h0, 32'h0);
        #1;
        total++; if ({I_EN_o, immed_o, RD_o, RWR_EN_o, ALUop_o} !== {1'b1, 32'hFFFFFFFB, 5'd1, 1'b1, 6'd0})
            begin bad++; $display("FAIL addi_dec got=%b %h %0d %b %0d", I_EN_o, immed_o, RD_o, RWR_EN_o, ALUop_o); end
        step();
        total++; if (result_o !== 32'hFFFFFFFB) begin bad++; $display("FAIL addi_res got=%h want=fffffffb", result_o); end
        drive(32'h402081B3, 32'h0, 32'd5, 32'd7);
        #1;
        total++; if ({R_EN_o, ALUop_o} !== {1'b1, 6'd1}) begin bad++; $display("FAIL sub_dec got=%b %0d want=1 1", R_EN_o, ALUop_o); end
        step();
        total++; if (result_o !== 32'hFFFFFFFE) begin bad++; $display("FAIL sub_res got=%h want=fffffffe", result_o); end
        drive(32'h4020D1B3, 32'h0, 32'h80000000, 32'd4);
        step();
        total++; if (result_o !== 32'hF8000000) begin bad++; $display("FAIL sra_res got=%h want=f8000000", result_o); end
        drive(32'hABCDE2B7, 32'h0, 32'h0, 32'h0);
        #1;
        total++; if ({U_EN_o, immed_o} !== {1'b1, 32'hABCDE000}) begin bad++; $display("FAIL lui_dec got=%b %h", U_EN_o, immed_o); end
        step();
        total++; if (result_o !== 32'hABCDE000) begin bad++; $display("FAIL lui_res got=%h want=abcde000", result_o); end
        drive(32'h000000EF, 32'h100, 32'h0, 32'h0);
        #1;
        total++; if ({UJE_o, UJ_EN_o} !== 2'b11) begin bad++; $display("FAIL jal_dec got=%b%b want=11", UJE_o, UJ_EN_o); end
        step();
        total++; if (result_o !== 32'h104) begin bad++; $display("FAIL jal_res got=%h want=104", result_o); end
    endtask

    task automatic test_branch();
        drive(32'hFE20CCE3, 32'h0, 32'hFFFFFFFF, 32'd1);
        #1;
        total++; if ({SB_EN_o, immed_o, BE_o} !== {1'b1, 32'hFFFFFFF8, 1'b1})
            begin bad++; $display("FAIL blt_dec got=%b %h %b", SB_EN_o, immed_o, BE_o); end
        drive(32'hFE20ECE3, 32'h0, 32'hFFFFFFFF, 32'd1);
        #1;
        total++; if ({BE_o, ALUop_o} !== {1'b0, 6'd20}) begin bad++; $display("FAIL bltu_dec got=%b %0d want=0 20", BE_o, ALUop_o); end
        step();
        total++; if (result_o !== 32'h0) begin bad++; $display("FAIL branch_res got=%h want=0", result_o); end
    endtask

    task automatic test_edge_cases();
        drive(32'h000000FF, 32'h0, 32'h0, 32'h0);
        #1;
        total++; if ({I_EN_o, R_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o, RWR_EN_o, ALUop_o, immed_o} !== 45'h0)
            begin bad++; $display("FAIL unk_op got=%b%b%b%b%b%b %b %0d %h", I_EN_o, R_EN_o, S_EN_o,
                                  SB_EN_o, U_EN_o, UJ_EN_o, RWR_EN_o, ALUop_o, immed_o); end
`ifdef DEC_ILLEGAL_EN
        total++; if (illegal_o !== 1'b1) begin bad++; $display("FAIL unk_illegal got=%b want=1", illegal_o); end
`endif
        drive(32'h00500013, 32'h0, 32'h0, 32'h0);
        #1;
        total++; if ({I_EN_o, RWR_EN_o} !== 2'b10) begin bad++; $display("FAIL addi_x0 got=%b%b want=10", I_EN_o, RWR_EN_o); end
    endtask

    task automatic test_back_to_back();
        logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        logic [31:0] ins, pc, a, b, fields;
        exp_t e, prev;
        logic have_prev;
        have_prev = 1'b0;
        prev = '0;
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            if ($urandom_range(7) != 0) ins[6:0] = ops[$urandom_range(8)];
            if (ins[6:0] == 7'h33 && $urandom_range(3) != 0) ins[31:25] = $urandom_range(1) ? 7'h20 : 7'h00;
            pc = $urandom & 32'hFFFFFFFC;
            a  = ($urandom_range(3) == 0) ? corner[$urandom_range(4)] : $urandom;
            b  = ($urandom_range(3) == 0) ? corner[$urandom_range(4)] : $urandom;
            if ($urandom_range(5) == 0) b = a;
            e = model(ins, pc, a, b);
            if (have_prev) begin
                total++;
                if (result_o !== prev.res) begin bad++; $display("FAIL rnd_result[%0d] got=%h want=%h", i, result_o, prev.res); end
            end
            drive(ins, pc, a, b);
            #1;
            fields = {RS1_o, RS2_o, RD_o, opcode_o, func3_o, func7_o};
            total++;
            if (fields !== {ins[19:15], ins[24:20], ins[11:7], ins[6:0], ins[14:12], ins[31:25]})
                begin bad++; $display("FAIL rnd_fields[%0d] instr=%h got=%h", i, ins, fields); end
            total++;
            if ({immed_o, ALUop_o, I_EN_o, R_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o, RWR_EN_o, BE_o, JALRE_o, UJE_o}
                !== {e.imm, e.op, e.en, e.rwr, e.be, e.jalr, e.jal})
                begin bad++; $display("FAIL rnd_ctrl[%0d] instr=%h got imm=%h op=%0d be=%b rwr=%b want imm=%h op=%0d be=%b rwr=%b",
                                      i, ins, immed_o, ALUop_o, BE_o, RWR_EN_o, e.imm, e.op, e.be, e.rwr); end
`ifdef DEC_ILLEGAL_EN
            total++;
            if (illegal_o !== e.ill) begin bad++; $display("FAIL rnd_illegal[%0d] instr=%h got=%b want=%b", i, ins, illegal_o, e.ill); end
`endif
            prev = e;
            have_prev = 1'b1;
            step();
        end
        total++;
        if (result_o !== prev.res) begin bad++; $display("FAIL rnd_result_last got=%h want=%h", result_o, prev.res); end
    endtask

    initial begin
        regrst_ni = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        @(posedge clk_i);
        #1;
        test_reset();
        step();
        test_alu_ops();
        test_branch();
        test_edge_cases();
        step();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_alu.md
Name: decode_ctrl_alu

Overview:
- Single-issue RV32I decode/control/execute slice.
- Splits the fetched instruction into fields, builds the sign-extended immediate, and generates type enables, register-write, branch/jump and ALU-op controls.
- Computes the ALU result, registered once.
- Sits between instruction memory/fetch (instr_i, pc_i) and the register file (rs data in; rd, write enable and result out).

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- regrst_ni  in  1  asynchronous active-low reset.
- instr_i  in  32  instruction word.
- pc_i  in  32  address of instr_i.
- rs1_data_i  in  32  register-file read data for RS1.
- rs2_data_i  in  32  register-file read data for RS2.
- RS1_o, RS2_o, RD_o  out  5 each  instr[19:15], [24:20], [11:7].
- opcode_o  out  7  instr[6:0].
- func3_o  out  3  instr[14:12].
- func7_o  out  7  instr[31:25].
- immed_o  out  32  sign-extended immediate.
- I_EN_o, R_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o  out  1 each  one-hot format enables.
- RWR_EN_o  out  1  register write enable.
- BE_o  out  1  conditional branch taken.
- JALRE_o  out  1  JALR.
- UJE_o  out  1  JAL.
- IWR_EN_o  out  1  instruction-memory write enable; constant 0.
- IR_EN_o  out  1  instruction-memory read enable; 0 during reset, else 1.
- ALUop_o  out  6  ALU operation code.
- result_o  out  32  registered ALU result.

Behaviour:
- Decode, control, immediate and ALUop are combinational from instr_i.
- result_o is registered: the result for instr_i at edge N is visible after edge N. Reset (async, regrst_ni=0) forces result_o=0.
- All control outputs are 0 while regrst_ni=0. IR_EN_o is 1 from release of reset onward.
- Formats by opcode:
  - R-type 0110011 -> R_EN.
  - OP-IMM 0010011, LOAD 0000011, JALR 1100111 -> I_EN.
  - STORE 0100011 -> S_EN.
  - BRANCH 1100011 -> SB_EN.
  - LUI 0110111, AUIPC 0010111 -> U_EN.
  - JAL 1101111 -> UJ_EN.
  - Any other opcode: all enables 0, RWR_EN=0, immed_o=0, ALUop=ADD (NOP).
- Immediates, each sign-extended from instr[31]:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - SB: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - UJ: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- RWR_EN=1 for R, OP-IMM, LOAD, JALR, LUI, AUIPC, JAL. It is 0 when RD=0.
- ALUop codes:
  - ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
  - BEQ 16, BNE 17, BLT 18, BGE 19, BLTU 20, BGEU 21.
  - LUI 32 (pass B), AUIPC 33 (pc+B), LINK 34 (pc+4).
- ALUop selection:
  - R-type: func3 plus func7[5] selects SUB vs ADD and SRA vs SRL.
  - OP-IMM: same, except func7[5] is honoured only for shifts; ADDI is never SUB.
  - LOAD/STORE: ADD.
  - BRANCH: 16+index of func3 {000,001,100,101,110,111}. Branch func3 010/011 -> NOP, BE_o=0.
  - JAL/JALR: LINK.
- Operands:
  - A = rs1_data_i.
  - B = rs2_data_i for R-type and BRANCH; immed_o otherwise.
- Arithmetic rules:
  - Arithmetic wraps mod 2^32.
  - Shift amount is B[4:0].
  - SLT/BLT/BGE use signed compare; SLTU/BLTU/BGEU use unsigned.
  - SLT/SLTU results are 0 or 1.
  - Branch ops: combinational BE_o = condition; result = 0.
- JALRE_o and UJE_o are asserted for the respective opcodes. Target computation belongs to fetch.

Optional Feature:
- Macro: DEC_ILLEGAL_EN.
- With the macro defined:
  - Add output illegal_o (1 bit).
  - illegal_o is asserted combinationally for unknown opcodes, bad branch func3, R-type func7 not in {0000000, 0100000}, or func7=0100000 on non-SUB/SRA.
  - When asserted, all write/branch/jump enables are forced to 0.
- Without the macro: no illegal_o port, and these encodings decode per the rules above.

Decomposition:
- Package decode_ctrl_alu_pkg holds: opcode localparams, the ALUop code enum (6-bit), and the format enum.
- One natural sub-module: decode_ctrl_alu_exec, the pure combinational ALU (ALUop, A, B, pc -> result, branch flag).
- Decode/control and the result register stay in the top.

Test Plan:
- Reset: hold regrst_ni=0 mid-run with result_o=0x1234 -> result_o=0 immediately, IR_EN_o=0, RWR_EN_o=0. Release -> IR_EN_o=1.
- ADDI x1,x0,-5 (0xFFB00093) -> I_EN=1, immed_o=0xFFFFFFFB, RD=1, RWR_EN=1, ALUop=0. After the next edge, result_o=0xFFFFFFFB.
- SUB x3,x1,x2 with rs1=5, rs2=7 -> R_EN=1, ALUop=1, result_o=0xFFFFFFFE. SRA with rs1=0x80000000, rs2=4 -> 0xF8000000.
- BLT x1,x2,-8 with rs1=0xFFFFFFFF, rs2=1 -> SB_EN=1, immed_o=0xFFFFFFF8, BE_o=1. BLTU with the same operands -> BE_o=0.
- LUI x5,0xABCDE -> U_EN=1, immed_o=0xABCDE000, result_o=0xABCDE000. JAL with pc_i=0x100 -> UJE_o=1, result_o=0x104.
- Opcode 0x7F -> all enables 0, RWR_EN=0. Under DEC_ILLEGAL_EN, illegal_o=1. ADDI with RD=0 -> RWR_EN=0.
